// File: rtl/pdm_pkg.sv
// Register map and STATUS word layout shared by the PDM sample feeder blocks.
// pdm_status() packs the flags and the fill count into the 16-bit STATUS read value.
package pdm_pkg;

  localparam logic PDM_ADR_SAMPLE = 1'b0;
  localparam logic PDM_ADR_STATUS = 1'b1;

  localparam int STATUS_UNDERRUN_BIT = 15;
  localparam int STATUS_FULL_BIT     = 14;
  localparam int STATUS_EMPTY_BIT    = 13;
  localparam int STATUS_COUNT_W      = 13;

  function automatic logic [15:0] pdm_status(input logic                      underrun,
                                             input logic                      full,
                                             input logic                      empty,
                                             input logic [STATUS_COUNT_W-1:0] count);
    logic [15:0] s;
    s                      = '0;
    s[STATUS_UNDERRUN_BIT] = underrun;
    s[STATUS_FULL_BIT]     = full;
    s[STATUS_EMPTY_BIT]    = empty;
    s[STATUS_COUNT_W-1:0]  = count;
    return s;
  endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Power-of-two synchronous FIFO holding PCM samples awaiting their sample tick.
// The head entry is readable combinationally so a pop and its data share one edge.
module pdm_sample_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_dat;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/wbs_pdm_feeder.sv
// Wishbone pipelined slave buffering PCM samples and releasing one per sample period
// to the PDM channel, with fill/underrun status and a low-water interrupt.
module wbs_pdm_feeder
  import pdm_pkg::*;
#(
  parameter int BIT_RESOLUTION  = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int CLK_DIV         = 256
) (
  input  logic                      wbs_clk_i,
  input  logic                      wbs_rst_ni,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic                      wbs_adr_i,
  input  logic [15:0]               wbs_dat_i,
  output logic [15:0]               wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic                      wbs_stall_o,
  output logic                      pdm_stb_o,
  output logic [BIT_RESOLUTION-1:0] pdm_dat_o,
  output logic                      irq_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] LOW_WATER =
    (FIFO_DEPTH_LOG2 + 1)'(1 << (FIFO_DEPTH_LOG2 - 1));

  logic [CNT_W-1:0]          cnt;
  logic                      tick;
  logic                      req;
  logic                      accept;
  logic                      push;
  logic                      pop;
  logic                      status_clr;
  logic                      underrun;
  logic [BIT_RESOLUTION-1:0] fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_DEPTH_LOG2:0]  fifo_count;
  logic [15:0]               status_word;

  pdm_sample_fifo #(
    .WIDTH      (BIT_RESOLUTION),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (wbs_clk_i),
    .rst_n    (wbs_rst_ni),
    .push     (push),
    .push_dat (wbs_dat_i[BIT_RESOLUTION-1:0]),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Stall only looks at registered fullness, so a pop on the same edge cannot lift it.
  assign req         = wbs_cyc_i & wbs_stb_i;
  assign wbs_stall_o = req & wbs_we_i & (wbs_adr_i == PDM_ADR_SAMPLE) & fifo_full;
  assign accept      = req & ~wbs_stall_o;
  assign push        = accept & wbs_we_i & (wbs_adr_i == PDM_ADR_SAMPLE);
  assign status_clr  = accept & wbs_we_i & (wbs_adr_i == PDM_ADR_STATUS);

  assign tick = (cnt == CNT_LAST);
  assign pop  = tick & ~fifo_empty;

  assign status_word = pdm_status(underrun, fifo_full, fifo_empty,
                                  STATUS_COUNT_W'(fifo_count));

  assign irq_o = underrun | (fifo_count < LOW_WATER);

  always_ff @(posedge wbs_clk_i) begin
    if (!wbs_rst_ni) begin
      cnt       <= '0;
      underrun  <= 1'b0;
      pdm_stb_o <= 1'b0;
      pdm_dat_o <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;

      // A fresh underrun outranks a software clear on the same edge.
      if (tick && fifo_empty) underrun <= 1'b1;
      else if (status_clr)    underrun <= 1'b0;

      pdm_stb_o <= pop;
      if (pop) pdm_dat_o <= fifo_head;

      wbs_ack_o <= accept;
      if (accept) begin
        wbs_dat_o <= (!wbs_we_i && (wbs_adr_i == PDM_ADR_STATUS)) ? status_word : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_wbs_pdm_feeder.sv
// Self-checking bench for wbs_pdm_feeder: a tick/fill/underrun model plus a sample
// scoreboard checked every cycle, and per-scenario tasks with inline checks.
module tb_wbs_pdm_feeder;

  localparam int BR    = 8;
  localparam int DL2   = 4;
  localparam int CD    = 10;
  localparam int DEPTH = 16;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          cyc    = 1'b0;
  logic          stb    = 1'b0;
  logic          we     = 1'b0;
  logic          adr    = 1'b0;
  logic [15:0]   dat_i  = 16'h0000;
  logic [15:0]   dat_o;
  logic          ack;
  logic          stall;
  logic          pdm_stb;
  logic [BR-1:0] pdm_dat;
  logic          irq;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  int            mdl_cnt  = 0;
  int            mdl_fill = 0;
  logic          mdl_unr  = 1'b0;
  logic          mdl_pop  = 1'b0;
  logic [BR-1:0] sb_q [$];

  wbs_pdm_feeder #(
    .BIT_RESOLUTION  (BR),
    .FIFO_DEPTH_LOG2 (DL2),
    .CLK_DIV         (CD)
  ) dut (
    .wbs_clk_i   (clk),
    .wbs_rst_ni  (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat_i),
    .wbs_dat_o   (dat_o),
    .wbs_ack_o   (ack),
    .wbs_stall_o (stall),
    .pdm_stb_o   (pdm_stb),
    .pdm_dat_o   (pdm_dat),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  function automatic logic exp_stall();
    return cyc && stb && we && !adr && (mdl_fill == DEPTH);
  endfunction

  // Reference behaviour, advanced on every active edge.
  always @(posedge clk) begin : model
    logic acc;
    logic tk;
    if (!rst_n) begin
      mdl_cnt  = 0;
      mdl_fill = 0;
      mdl_unr  = 1'b0;
      mdl_pop  = 1'b0;
      sb_q.delete();
    end else begin
      acc     = cyc && stb && !exp_stall();
      tk      = (mdl_cnt == CD - 1);
      mdl_pop = tk && (mdl_fill > 0);
      if (tk && mdl_fill == 0)   mdl_unr = 1'b1;
      else if (acc && we && adr) mdl_unr = 1'b0;
      if (acc && we && !adr) begin
        sb_q.push_back(dat_i[BR-1:0]);
        mdl_fill++;
      end
      if (mdl_pop) mdl_fill--;
      mdl_cnt = tk ? 0 : mdl_cnt + 1;
    end
  end

  always @(negedge clk) begin : monitor
    logic [BR-1:0] e;
    if (chk_en) begin
      total++;
      if (stall !== exp_stall()) begin
        bad++;
        $display("FAIL stall t=%0t: got %b want %b", $time, stall, exp_stall());
      end
      total++;
      if (irq !== (mdl_unr || (mdl_fill < DEPTH / 2))) begin
        bad++;
        $display("FAIL irq t=%0t: got %b want %b", $time, irq, (mdl_unr || (mdl_fill < DEPTH / 2)));
      end
      total++;
      if (pdm_stb !== mdl_pop) begin
        bad++;
        $display("FAIL pdm_stb t=%0t: got %b want %b", $time, pdm_stb, mdl_pop);
      end
      if (mdl_pop) begin
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else                 e = '0;
        total++;
        if (pdm_dat !== e) begin
          bad++;
          $display("FAIL pdm_dat t=%0t: got %h want %h", $time, pdm_dat, e);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0; dat_i = '0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wb_single(input logic w, input logic a, input logic [15:0] d,
                           output logic [15:0] rd, output int acks);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    @(negedge clk);
    while (stall && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    acks = int'(ack);
    rd   = dat_o;
    @(negedge clk);
    acks += int'(ack);
  endtask

  task automatic wb_burst(input int n, input logic [15:0] base, input logic [15:0] step,
                          output int n_acc, output int acks, output int stalls);
    int   guard;
    logic go;
    guard = 0; n_acc = 0; acks = 0; stalls = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 1'b0; dat_i = base;
    while (n_acc < n && guard < 400) begin
      @(negedge clk);
      acks += int'(ack);
      go = !stall;
      if (!go) stalls++;
      @(posedge clk); #1;
      if (go) begin
        n_acc++;
        dat_i = base + step * 16'(n_acc);
      end
      guard++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    acks += int'(ack);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((mdl_fill != 0 || sb_q.size() != 0) && g < 600) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_cnt(input int v);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (mdl_cnt != v && g < 2 * CD);
  endtask

  task automatic test_reset();
    int            first;
    int            k;
    logic [BR-1:0] first_dat;
    @(posedge clk); #1;
    rst_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 1'b0; dat_i = 16'hff55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    total++;
    if ({pdm_stb, pdm_dat, ack, dat_o} !== '0) begin
      bad++;
      $display("FAIL reset_regs: got stb=%b dat=%h ack=%b rdat=%h want all 0", pdm_stb, pdm_dat, ack, dat_o);
    end
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL reset_irq: got %b want 1", irq);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall: got %b want 0", stall);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    first = 0; k = 0; first_dat = '0;
    repeat (2 * CD) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        total++;
        if (ack !== 1'b1) begin
          bad++;
          $display("FAIL reset_first_ack: got %b want 1", ack);
        end
      end
      if (pdm_stb === 1'b1 && first == 0) begin
        first     = k;
        first_dat = pdm_dat;
      end
    end
    total++;
    if (first != CD) begin
      bad++;
      $display("FAIL first_tick: got edge %0d want %0d", first, CD);
    end
    total++;
    if (first_dat !== 8'h55) begin
      bad++;
      $display("FAIL first_dat: got %h want 55", first_dat);
    end
  endtask

  task automatic test_stream();
    int            n_acc, acks, stalls, ns, k;
    int            times [3];
    logic [BR-1:0] vals [3];
    logic [15:0]   rd;
    logic [BR-1:0] want [3];
    want[0] = 8'h10; want[1] = 8'h20; want[2] = 8'h30;
    do_reset(2);
    wb_burst(3, 16'h0010, 16'h0010, n_acc, acks, stalls);
    total++;
    if (acks != 3) begin
      bad++;
      $display("FAIL stream_acks: got %0d want 3", acks);
    end
    ns = 0; k = 0;
    repeat (4 * CD) begin
      @(negedge clk);
      k++;
      if (pdm_stb === 1'b1) begin
        if (ns < 3) begin
          times[ns] = k;
          vals[ns]  = pdm_dat;
        end
        ns++;
      end
    end
    total++;
    if (ns != 3) begin
      bad++;
      $display("FAIL stream_count: got %0d strobes want 3", ns);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (vals[i] !== want[i]) begin
          bad++;
          $display("FAIL stream_val%0d: got %h want %h", i, vals[i], want[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (times[i] - times[i-1] != CD) begin
          bad++;
          $display("FAIL stream_gap%0d: got %0d want %0d", i, times[i] - times[i-1], CD);
        end
      end
    end
    total++;
    if (pdm_dat !== 8'h30) begin
      bad++;
      $display("FAIL stream_hold: got %h want 30", pdm_dat);
    end
    wb_single(1'b0, 1'b1, 16'h0000, rd, acks);
    total++;
    if (rd !== 16'hA000 || acks != 1) begin
      bad++;
      $display("FAIL stream_status: got %h acks=%0d want a000 acks=1", rd, acks);
    end
  endtask

  task automatic test_status();
    int          n_acc, acks, stalls;
    logic [15:0] rd;
    do_reset(2);
    wb_burst(5, 16'h0001, 16'h0001, n_acc, acks, stalls);
    wb_single(1'b0, 1'b1, 16'h0000, rd, acks);
    total++;
    if (rd !== 16'h0005 || acks != 1) begin
      bad++;
      $display("FAIL status_5: got %h acks=%0d want 0005 acks=1", rd, acks);
    end
    wb_single(1'b0, 1'b0, 16'h0000, rd, acks);
    total++;
    if (rd !== 16'h0000 || acks != 1) begin
      bad++;
      $display("FAIL sample_read: got %h acks=%0d want 0000 acks=1", rd, acks);
    end
    wait_drain();
    wait_cnt(0);
    wait_cnt(0);
    wb_single(1'b0, 1'b1, 16'h0000, rd, acks);
    total++;
    if (rd !== 16'hA000) begin
      bad++;
      $display("FAIL status_underrun: got %h want a000", rd);
    end
    wait_cnt(0);
    wb_single(1'b1, 1'b1, 16'h1234, rd, acks);
    wb_single(1'b0, 1'b1, 16'h0000, rd, acks);
    total++;
    if (rd !== 16'h2000) begin
      bad++;
      $display("FAIL status_clear: got %h want 2000", rd);
    end
    wait_cnt(CD - 2);
    wb_single(1'b1, 1'b1, 16'hffff, rd, acks);
    wb_single(1'b0, 1'b1, 16'h0000, rd, acks);
    total++;
    if (rd !== 16'hA000) begin
      bad++;
      $display("FAIL clear_vs_tick: got %h want a000", rd);
    end
  endtask

  task automatic test_full();
    int n_acc, acks, stalls;
    do_reset(2);
    wb_burst(24, 16'hA500, 16'h0001, n_acc, acks, stalls);
    total++;
    if (n_acc != 24) begin
      bad++;
      $display("FAIL full_accepted: got %0d want 24", n_acc);
    end
    total++;
    if (acks != n_acc) begin
      bad++;
      $display("FAIL full_acks: got %0d want %0d", acks, n_acc);
    end
    total++;
    if (stalls < 1) begin
      bad++;
      $display("FAIL full_stalled: got %0d stall cycles want >0", stalls);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int          n_acc, acks, stalls, ns;
    logic [15:0] rd;
    do_reset(2);
    wb_burst(8, 16'h0060, 16'h0001, n_acc, acks, stalls);
    rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 1'b1;
    @(negedge clk);
    total++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_ack: got %b want 0", ack);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_ack2: got %b want 0", ack);
    end
    wb_single(1'b0, 1'b1, 16'h0000, rd, acks);
    total++;
    if (rd !== 16'h2000) begin
      bad++;
      $display("FAIL mid_reset_status: got %h want 2000", rd);
    end
    ns = 0;
    repeat (3 * CD) begin
      @(negedge clk);
      if (pdm_stb === 1'b1) ns++;
    end
    total++;
    if (ns != 0) begin
      bad++;
      $display("FAIL mid_reset_quiet: got %0d strobes want 0", ns);
    end
    wb_single(1'b1, 1'b0, 16'h0077, rd, acks);
    ns = 0;
    repeat (2 * CD + 2) begin
      @(negedge clk);
      if (pdm_stb === 1'b1 && pdm_dat === 8'h77) ns++;
    end
    total++;
    if (ns != 1) begin
      bad++;
      $display("FAIL mid_reset_resume: got %0d strobes of 77 want 1", ns);
    end
  endtask

  task automatic test_no_cycle();
    int          acks, a;
    logic [15:0] rd;
    do_reset(2);
    acks = 0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 1'b0; dat_i = 16'h0011;
    repeat (2) begin
      @(negedge clk);
      acks += int'(ack);
    end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b0;
    repeat (2) begin
      @(negedge clk);
      acks += int'(ack);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    acks += int'(ack);
    total++;
    if (acks != 0) begin
      bad++;
      $display("FAIL no_cycle_ack: got %0d acks want 0", acks);
    end
    wb_single(1'b0, 1'b1, 16'h0000, rd, a);
    total++;
    if (rd !== 16'h2000) begin
      bad++;
      $display("FAIL no_cycle_status: got %h want 2000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_status();
    test_full();
    test_reset_mid();
    test_no_cycle();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
